// File: rtl/wb_port_sched.sv
// Write-back port scheduler: shares one register-file write port between scalar
// results and matrix results, which it writes out one word at a time.
module wb_port_sched #(
   parameter int DATA_W    = 32,
   parameter int MAT_BEATS = 4,
   parameter int ADDR_W    = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [1:0]                  in_w_select,
   input  logic [ADDR_W-1:0]           in_rd,
   input  logic [DATA_W-1:0]           in_alu_o,
   input  logic [DATA_W-1:0]           in_mem_data,
   input  logic [DATA_W*MAT_BEATS-1:0] in_matrix_o,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_waddr,
   output logic [DATA_W-1:0]           rf_wdata,
   output logic                        mat_busy
);

   localparam int BEAT_W = (MAT_BEATS > 1) ? $clog2(MAT_BEATS) : 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                      state_reg, state_next;
   logic [BEAT_W-1:0]           beat_reg, beat_next;
   logic [ADDR_W-1:0]           base_reg, base_next;
   logic [DATA_W*MAT_BEATS-1:0] mat_reg, mat_next;
   logic                        rf_we_reg, rf_we_next;
   logic [ADDR_W-1:0]           rf_waddr_reg, rf_waddr_next;
   logic [DATA_W-1:0]           rf_wdata_reg, rf_wdata_next;

   logic [DATA_W-1:0] mat_words_reg [MAT_BEATS];
   logic [DATA_W-1:0] mat_words_in  [MAT_BEATS];

   generate
      for (genvar gi = 0; gi < MAT_BEATS; gi++) begin : g_words
         assign mat_words_reg[gi] = mat_reg[gi*DATA_W +: DATA_W];
         assign mat_words_in[gi]  = in_matrix_o[gi*DATA_W +: DATA_W];
      end
   endgenerate

   logic              last_beat;
   logic              accept;
   logic [BEAT_W-1:0] beat_inc;
   logic [ADDR_W-1:0] beat_addr;

   assign last_beat = (state_reg == BURST) && (beat_reg == BEAT_W'(MAT_BEATS - 1));
   // Ready on the final beat too, so back-to-back transfers see no bubble.
   assign in_ready  = rst && ((state_reg == IDLE) || last_beat);
   assign accept    = in_valid && in_ready;
   assign beat_inc  = beat_reg + 1'b1;
   assign beat_addr = base_reg + ADDR_W'(beat_inc);

   always_comb begin
      state_next    = state_reg;
      beat_next     = beat_reg;
      base_next     = base_reg;
      mat_next      = mat_reg;
      rf_we_next    = 1'b0;
      rf_waddr_next = rf_waddr_reg;
      rf_wdata_next = rf_wdata_reg;

      if (state_reg == BURST && !last_beat) begin
         beat_next     = beat_inc;
         rf_we_next    = (beat_addr != '0);
         rf_waddr_next = beat_addr;
         rf_wdata_next = mat_words_reg[beat_inc];
      end else begin
         state_next = IDLE;
         if (accept) begin
            case (in_w_select)
               2'b00, 2'b01: begin
                  rf_we_next    = (in_rd != '0);
                  rf_waddr_next = in_rd;
                  rf_wdata_next = (in_w_select == 2'b00) ? in_alu_o : in_mem_data;
               end
               2'b10: begin
                  // Word 0 is registered at the accept edge so beats land in N+1..N+MAT_BEATS.
                  state_next    = BURST;
                  beat_next     = '0;
                  base_next     = in_rd;
                  mat_next      = in_matrix_o;
                  rf_we_next    = (in_rd != '0);
                  rf_waddr_next = in_rd;
                  rf_wdata_next = mat_words_in[0];
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         beat_reg     <= '0;
         base_reg     <= '0;
         mat_reg      <= '0;
         rf_we_reg    <= 1'b0;
         rf_waddr_reg <= '0;
         rf_wdata_reg <= '0;
      end else begin
         state_reg    <= state_next;
         beat_reg     <= beat_next;
         base_reg     <= base_next;
         mat_reg      <= mat_next;
         rf_we_reg    <= rf_we_next;
         rf_waddr_reg <= rf_waddr_next;
         rf_wdata_reg <= rf_wdata_next;
      end
   end

   assign rf_we    = rf_we_reg;
   assign rf_waddr = rf_waddr_reg;
   assign rf_wdata = rf_wdata_reg;
   assign mat_busy = (state_reg == BURST);

endmodule

// File: tb/tb_wb_port_sched.sv
// Bench for wb_port_sched: scoreboard of expected register writes plus per-cycle timing checks.
module tb_wb_port_sched;
   localparam int DW = 32;
   localparam int MB = 4;
   localparam int AW = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       in_w_select = 2'b11;
   logic [AW-1:0]    in_rd = '0;
   logic [DW-1:0]    in_alu_o = '0;
   logic [DW-1:0]    in_mem_data = '0;
   logic [DW*MB-1:0] in_matrix_o = '0;
   logic             rf_we;
   logic [AW-1:0]    rf_waddr;
   logic [DW-1:0]    rf_wdata;
   logic             mat_busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;
   wr_t exp_q[$];

   wb_port_sched #(.DATA_W(DW), .MAT_BEATS(MB), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_w_select(in_w_select), .in_rd(in_rd), .in_alu_o(in_alu_o),
      .in_mem_data(in_mem_data), .in_matrix_o(in_matrix_o),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mat_busy(mat_busy)
   );

   always #5 clk = ~clk;

   // Every observed write is popped from the scoreboard and compared.
   always @(negedge clk) begin
      wr_t e;
      if (rf_we === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got write x%0d=%h, required no write", rf_waddr, rf_wdata);
         end else begin
            e = exp_q.pop_front();
            if (rf_waddr !== e.a || rf_wdata !== e.d) begin
               n_fail++;
               $display("FAIL sb_write: got x%0d=%h, required x%0d=%h", rf_waddr, rf_wdata, e.a, e.d);
            end else
               $display("write x%0d=%h ok", rf_waddr, rf_wdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] sel, input logic [AW-1:0] rd,
                        input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                        input logic [DW*MB-1:0] mat);
      in_valid = v; in_w_select = sel; in_rd = rd;
      in_alu_o = alu; in_mem_data = mem; in_matrix_o = mat;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      if (a != '0) exp_q.push_back(e);
   endtask

   task automatic push_matrix(input logic [AW-1:0] base, input logic [DW*MB-1:0] m);
      for (int k = 0; k < MB; k++) push(base + AW'(k), m[k*DW +: DW]);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) step();
      n_checks++;
      if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
         n_fail++; $display("FAIL reset_rf: got we=%b addr=%0d data=%h, required 0/0/0", rf_we, rf_waddr, rf_wdata);
      end
      n_checks++;
      if (mat_busy !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctl: got busy=%b ready=%b, required 0/0", mat_busy, in_ready);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %b, required 1", in_ready);
      end
      $display("reset done");
   endtask

   task automatic test_alu();
      drive(1'b1, 2'b00, 5'd5, 32'h12345678, 32'h0, '0);
      push(5'd5, 32'h12345678);
      step();
      in_valid = 1'b0;
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h12345678) begin
         n_fail++; $display("FAIL alu_write: got we=%b x%0d=%h, required 1 x5=12345678", rf_we, rf_waddr, rf_wdata);
      end
      step();
      n_checks++;
      if (rf_we !== 1'b0) begin
         n_fail++; $display("FAIL alu_after: got we=%b, required 0", rf_we);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 2'b01, 5'd7, 32'h0, 32'hDEADBEEF, '0);
      push(5'd7, 32'hDEADBEEF);
      step();
      drive(1'b1, 2'b11, 5'd9, 32'h1111, 32'h2222, '0);
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_mem: got we=%b x%0d=%h ready=%b, required 1 x7=deadbeef 1", rf_we, rf_waddr, rf_wdata, in_ready);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_nowrite: got we=%b ready=%b, required 0/1", rf_we, in_ready);
      end
   endtask

   task automatic test_matrix_then_scalar();
      logic [DW*MB-1:0] m;
      m = 128'h44444444_33333333_22222222_11111111;
      drive(1'b1, 2'b10, 5'd8, 32'h0, 32'h0, m);
      push_matrix(5'd8, m);
      step();
      drive(1'b1, 2'b00, 5'd3, 32'h000000A5, 32'h0, '0);
      push(5'd3, 32'h000000A5);
      for (int b = 0; b < MB; b++) begin
         n_checks++;
         if (rf_we !== 1'b1 || rf_waddr !== AW'(8 + b) || rf_wdata !== m[b*DW +: DW]) begin
            n_fail++; $display("FAIL mat_beat%0d: got we=%b x%0d=%h, required 1 x%0d=%h", b, rf_we, rf_waddr, rf_wdata, 8 + b, m[b*DW +: DW]);
         end
         n_checks++;
         if (mat_busy !== 1'b1 || in_ready !== (b == MB - 1)) begin
            n_fail++; $display("FAIL mat_ctl%0d: got busy=%b ready=%b, required 1/%b", b, mat_busy, in_ready, b == MB - 1);
         end
         step();
      end
      in_valid = 1'b0;
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA5 || mat_busy !== 1'b0) begin
         n_fail++; $display("FAIL mat_scalar: got we=%b x%0d=%h busy=%b, required 1 x3=a5 0", rf_we, rf_waddr, rf_wdata, mat_busy);
      end
      step();
      n_checks++;
      if (rf_we !== 1'b0) begin
         n_fail++; $display("FAIL mat_scalar_after: got we=%b, required 0", rf_we);
      end
   endtask

   task automatic test_back_to_back_matrix();
      logic [DW*MB-1:0] m1;
      logic [DW*MB-1:0] m2;
      m1 = 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1;
      m2 = 128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1;
      drive(1'b1, 2'b10, 5'd16, 32'h0, 32'h0, m1);
      push_matrix(5'd16, m1);
      step();
      drive(1'b1, 2'b10, 5'd20, 32'h0, 32'h0, m2);
      push_matrix(5'd20, m2);
      for (int b = 0; b < 2 * MB; b++) begin
         n_checks++;
         if (mat_busy !== 1'b1 || in_ready !== ((b % MB) == MB - 1)) begin
            n_fail++; $display("FAIL mm_ctl%0d: got busy=%b ready=%b, required 1/%b", b, mat_busy, in_ready, (b % MB) == MB - 1);
         end
         step();
         if (b == MB - 1) in_valid = 1'b0;
      end
      n_checks++;
      if (mat_busy !== 1'b0 || rf_we !== 1'b0) begin
         n_fail++; $display("FAIL mm_end: got busy=%b we=%b, required 0/0", mat_busy, rf_we);
      end
   endtask

   task automatic test_wrap_x0();
      logic [DW*MB-1:0] m;
      logic [AW-1:0]    a;
      m = 128'h0000D003_0000D002_0000D001_0000D000;
      drive(1'b1, 2'b10, 5'd30, 32'h0, 32'h0, m);
      push_matrix(5'd30, m);
      step();
      in_valid = 1'b0;
      for (int b = 0; b < MB; b++) begin
         a = AW'(30 + b);
         n_checks++;
         if (rf_we !== (a != '0) || (a != '0 && rf_waddr !== a) || mat_busy !== 1'b1) begin
            n_fail++; $display("FAIL wrap_beat%0d: got we=%b x%0d busy=%b, required %b x%0d 1", b, rf_we, rf_waddr, mat_busy, a != '0, a);
         end
         step();
      end
      n_checks++;
      if (mat_busy !== 1'b0 || rf_we !== 1'b0) begin
         n_fail++; $display("FAIL wrap_end: got busy=%b we=%b, required 0/0", mat_busy, rf_we);
      end
      drive(1'b1, 2'b00, 5'd0, 32'h77777777, 32'h0, '0);
      step();
      in_valid = 1'b0;
      n_checks++;
      if (rf_we !== 1'b0) begin
         n_fail++; $display("FAIL x0_scalar: got we=%b, required 0", rf_we);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [DW*MB-1:0] m;
      m = 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1;
      drive(1'b1, 2'b10, 5'd12, 32'h0, 32'h0, m);
      push(5'd12, m[0 +: DW]);
      push(5'd13, m[DW +: DW]);
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_ready: got %b, required 0", in_ready);
      end
      step();
      n_checks++;
      if (rf_we !== 1'b0 || mat_busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_abort: got we=%b busy=%b, required 0/0", rf_we, mat_busy);
      end
      step();
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || mat_busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_release: got ready=%b busy=%b, required 1/0", in_ready, mat_busy);
      end
      for (int c = 0; c < 6; c++) begin
         step();
         n_checks++;
         if (rf_we !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_residual%0d: got we=%b, required 0", c, rf_we);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_matrix_then_scalar();
      test_back_to_back_matrix();
      test_wrap_x0();
      test_reset_mid_burst();
      repeat (2) step();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL sb_drain: got %0d pending writes, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_port_sched.md
Name: wb_port_sched

Overview:
- Write-back port scheduler between the MEM/WB pipeline register and the scalar register file.
- Arbitrates the single 32-bit register-file write port between:
  - scalar results (ALU or memory load);
  - 128-bit matrix results, serialised into MAT_BEATS consecutive 32-bit register writes.
- Back-pressures the pipeline with a valid/ready handshake while a matrix burst drains.

Parameters:
- DATA_W, 32, width of one register-file word.
- MAT_BEATS, 4, number of register writes per matrix result; matrix input width = DATA_W*MAT_BEATS.
- ADDR_W, 5, register address width; 32 registers, x0 hard-wired zero.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- in_valid  input  1  write-back slot valid.
- in_ready  output  1  scheduler can accept this cycle.
- in_w_select  input  2  source select: 00 ALU, 01 memory, 10 matrix, 11 no write.
- in_rd  input  ADDR_W  destination register; base register for a matrix burst.
- in_alu_o  input  DATA_W  ALU result.
- in_mem_data  input  DATA_W  load data.
- in_matrix_o  input  DATA_W*MAT_BEATS  matrix result; word k = bits [32k+31:32k].
- rf_we  output  1  register-file write enable.
- rf_waddr  output  ADDR_W  register-file write address.
- rf_wdata  output  DATA_W  register-file write data.
- mat_busy  output  1  matrix burst in progress.

Behaviour:
- Reset: clocked, checked only at the rising edge when rst=0. While in reset:
  - rf_we=0, rf_waddr=0, rf_wdata=0, mat_busy=0, state=IDLE, beat counter=0, latched matrix data=0.
  - in_ready=0 throughout reset.
  - Reset asserted mid-burst abandons the remaining beats; no further rf_we.
- Accept: a transfer is accepted in cycle N when in_valid & in_ready at the rising edge.
- All rf_* outputs are registered.
- State IDLE:
  - in_ready=1.
  - Accept with select 00 or 01: cycle N+1 drives rf_we=1, rf_waddr=in_rd, rf_wdata=ALU result or load data respectively.
  - Accept with select 11: no write; rf_we=0 in N+1.
  - Accept with select 10: latch in_matrix_o and in_rd, go to BURST with beat=0, mat_busy=1 from N+1.
  - No accept: rf_we=0 next cycle.
- State BURST:
  - Each cycle drives rf_we=1, rf_waddr=(base+beat) mod 32, rf_wdata=latched word[beat], then beat increments.
  - Beats occur in cycles N+1 .. N+MAT_BEATS.
- in_ready during BURST:
  - 0 while beat < MAT_BEATS-1.
  - 1 on the final beat, so a new transfer can be accepted with no bubble.
  - Therefore for MAT_BEATS=4: in_ready is low in N+1..N+3 and high in N+4.
- Leaving BURST after the final beat:
  - If a scalar was accepted on that beat, its write occurs the next cycle and state returns to IDLE.
  - If a matrix was accepted, a new BURST starts immediately with beat=0 and mat_busy stays 1.
  - Otherwise state returns to IDLE with mat_busy=0.
- x0 rule: any write (scalar or matrix beat) whose address is 0 drives rf_we=0. For a matrix beat, the beat slot is still consumed and the timing is unchanged.
- Wrap: base+beat is computed modulo 2^ADDR_W. Example: base 30 writes x30, x31, then x0 (suppressed), then x1.
- in_ready is combinational from state and beat only; it never depends on in_valid.
- in_valid with in_ready=0: the upstream holds its inputs stable; inputs are ignored until accepted.
- Output hold: rf_wdata and rf_waddr hold their last values when rf_we=0; only rf_we is required to be 0.

Test Plan:
- Scalar ALU: accept {sel=00, rd=5, alu=0x12345678} at N → N+1: rf_we=1, waddr=5, wdata=0x12345678; N+2: rf_we=0.
- Memory then no-write back-to-back: accept {01, rd=7, mem=0xDEADBEEF} at N, then {11, rd=9} at N+1 → N+1: write x7=0xDEADBEEF; N+2: rf_we=0; in_ready=1 throughout.
- Matrix burst: accept {10, rd=8, matrix=0x44444444_33333333_22222222_11111111} at N → writes x8=0x11111111, x9=0x22222222, x10=0x33333333, x11=0x44444444 in N+1..N+4; in_ready=0 in N+1..N+3; mat_busy=1 in N+1..N+4.
- Matrix then scalar, no bubble: hold {00, rd=3, alu=0xA5} valid from N+1 → accepted at N+4, x3=0xA5 written at N+5; mat_busy=0 at N+5.
- Wrap and x0: matrix with rd=30 → beats to x30, x31, (x0 suppressed, rf_we=0), x1; four beat cycles total; scalar with rd=0 → rf_we=0.
- Reset mid-burst: rst=0 at N+2 of a burst → rf_we=0 from the next edge; after release, state=IDLE, in_ready=1, mat_busy=0, no residual beats.
